axi_slave2_mem: RTL and testbench

AXI_SLAVE2_MEM -- requirements
Module: axi_slave2_mem

---
 rtl/axi_slave2_mem_pkg.sv | 31 +++
 rtl/axi_slave2_ram.sv | 41 ++++
 rtl/axi_slave2_mem.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi_slave2_mem.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave2_mem_pkg.sv
// Shared Slave-2 definitions: response/burst encodings, address window and FSM states.
// Imported by the Slave-2 memory responder and its RAM.
package axi_slave2_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic [31:0] S2_BASE_ADDR = 32'h0000_4000;
    localparam logic [31:0] S2_END_ADDR  = 32'h0000_4FFF;
    localparam int unsigned S2_DEPTH_WORDS = (S2_END_ADDR - S2_BASE_ADDR + 32'd1) >> 2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    // Encodings are ordered so that numeric order equals severity order.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_slave2_ram.sv
// Byte-enabled 1W/1R synchronous RAM; read port is read-before-write and holds its
// output register whenever no read is issued.
module axi_slave2_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [0:DEPTH_WORDS-1];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave2_mem.sv
// AXI4 memory responder behind the Slave-2 port: one outstanding write and one
// outstanding read, independent channels, INCR/FIXED bursts of 4-byte beats.
module axi_slave2_mem
    import axi_slave2_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = S2_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = S2_DEPTH_WORDS,
    parameter int unsigned ID_W        = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd1;

    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [1:0] burst,
                                             input logic [2:0] size);
        logic [1:0] resp;
        resp = RESP_OKAY;
        if (size != SIZE_WORD) begin
            resp = RESP_SLVERR;
        end else begin
            case (burst)
                BURST_INCR, BURST_FIXED: begin
                    if ((addr < BASE_ADDR) || (addr > END_ADDR)) resp = RESP_DECERR;
                end
                BURST_WRAP: resp = RESP_SLVERR;
                default:    resp = RESP_SLVERR;
            endcase
        end
        return resp;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

    logic [1:0]      w_state_q, w_state_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d, w_acc_q, w_acc_d;
    logic [31:0]     w_addr_q, w_addr_d;
    logic [7:0]      w_len_q, w_len_d;
    logic [2:0]      w_size_q, w_size_d;
    logic [1:0]      w_burst_q, w_burst_d;
    logic [8:0]      w_cnt_q, w_cnt_d;
    logic [8:0]      w_cnt_inc;
    logic [1:0]      w_beat_resp, w_burst_resp;
    logic            w_at_count;

    logic            r_state_q, r_state_d;
    logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, r_ok_q, r_ok_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [31:0]     r_addr_q, r_addr_d, r_issue_addr;
    logic [7:0]      r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [2:0]      r_size_q, r_size_d;
    logic [1:0]      r_burst_q, r_burst_d, r_resp_n;

    logic            ram_we, ram_re;
    logic [31:0]     ram_rdata;

    // Write channel: accept AW, absorb beats up to the count or wlast, then respond.
    always_comb begin
        w_state_d    = w_state_q;
        awready_d    = awready_q;
        wready_d     = wready_q;
        bvalid_d     = bvalid_q;
        bid_d        = bid_q;
        bresp_d      = bresp_q;
        w_acc_d      = w_acc_q;
        w_addr_d     = w_addr_q;
        w_len_d      = w_len_q;
        w_size_d     = w_size_q;
        w_burst_d    = w_burst_q;
        w_cnt_d      = w_cnt_q;
        w_cnt_inc    = w_cnt_q + 9'd1;
        w_beat_resp  = beat_resp(w_addr_q, w_burst_q, w_size_q);
        w_burst_resp = worst_resp(w_acc_q, w_beat_resp);
        w_at_count   = (w_cnt_inc == 9'(w_len_q) + 9'd1);
        ram_we       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awready_q && awvalid) begin
                    bid_d     = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_cnt_d   = 9'd0;
                    w_acc_d   = RESP_OKAY;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wready_q && wvalid) begin
                    ram_we   = (w_beat_resp == RESP_OKAY) && !rst;
                    w_acc_d  = w_burst_resp;
                    w_cnt_d  = w_cnt_inc;
                    w_addr_d = next_addr(w_addr_q, w_burst_q);
                    if (wlast || w_at_count) begin
                        // wlast must land exactly on the counted last beat
                        bresp_d   = (wlast && w_at_count) ? w_burst_resp
                                                          : worst_resp(w_burst_resp, RESP_SLVERR);
                        bvalid_d  = 1'b1;
                        wready_d  = 1'b0;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: each issued beat is read from RAM one cycle ahead of its rvalid.
    always_comb begin
        r_state_d    = r_state_q;
        arready_d    = arready_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        r_ok_d       = r_ok_q;
        rid_d        = rid_q;
        rresp_d      = rresp_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_beat_d     = r_beat_q;
        r_size_d     = r_size_q;
        r_burst_d    = r_burst_q;
        r_issue_addr = r_addr_q;
        r_resp_n     = RESP_OKAY;
        ram_re       = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && arvalid) begin
                    r_issue_addr = araddr;
                    r_resp_n     = beat_resp(araddr, arburst, arsize);
                    ram_re       = (r_resp_n == RESP_OKAY) && !rst;
                    r_ok_d       = (r_resp_n == RESP_OKAY);
                    rresp_d      = r_resp_n;
                    rid_d        = arid;
                    r_addr_d     = araddr;
                    r_len_d      = arlen;
                    r_size_d     = arsize;
                    r_burst_d    = arburst;
                    r_beat_d     = 8'd0;
                    rlast_d      = (arlen == 8'd0);
                    rvalid_d     = 1'b1;
                    arready_d    = 1'b0;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_issue_addr = next_addr(r_addr_q, r_burst_q);
                        r_resp_n     = beat_resp(r_issue_addr, r_burst_q, r_size_q);
                        ram_re       = (r_resp_n == RESP_OKAY) && !rst;
                        r_ok_d       = (r_resp_n == RESP_OKAY);
                        rresp_d      = r_resp_n;
                        r_addr_d     = r_issue_addr;
                        r_beat_d     = r_beat_q + 8'd1;
                        rlast_d      = (r_beat_d == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_acc_q   <= RESP_OKAY;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            r_ok_q    <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_acc_q   <= w_acc_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            r_ok_q    <= r_ok_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
        end
    end

    axi_slave2_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_idx(w_addr_q)),
        .wdata (wdata),
        .wstrb (wstrb),
        .re    (ram_re),
        .raddr (word_idx(r_issue_addr)),
        .rdata (ram_rdata)
    );

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    // Error beats never read the RAM, so their data is forced to zero here.
    assign rdata   = ram_rdata & {32{r_ok_q}};

endmodule

// File: tb/tb_axi_slave2_mem.sv
// Directed bench for axi_slave2_mem: inputs driven and outputs sampled on the falling edge.
module tb_axi_slave2_mem;

    localparam int unsigned ID_W = 6;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic            clk = 1'b0;
    logic            rst;
    logic [ID_W-1:0] awid, arid, bid, rid;
    logic [31:0]     awaddr, araddr, wdata, rdata;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [3:0]      wstrb;

    int checks = 0;
    int errors = 0;

    logic [31:0]     wr_data [16];
    logic [3:0]      wr_strb [16];
    logic [31:0]     rd_data [16];
    logic [1:0]      rd_resp [16];
    logic            rd_last [16];
    logic [ID_W-1:0] rd_id   [16];
    logic [ID_W-1:0] b_id;
    logic [1:0]      b_resp;

    axi_slave2_mem #(.BASE_ADDR(32'h0000_4000), .DEPTH_WORDS(1024), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete, required finish");
        $fatal(1);
    end

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && k < 50) begin @(negedge clk); k++; end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout awready=%0b required=1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == last_at); wvalid = 1'b1;
            while (!wready && k < 50) begin @(negedge clk); k++; end
            if (!wready) begin
                checks++; errors++;
                $display("FAIL w_timeout beat=%0d wready=%0b required=1", i, wready);
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv();
        int k = 0;
        bready = 1'b1;
        while (!bvalid && k < 50) begin @(negedge clk); k++; end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL b_timeout bvalid=%0b required=1", bvalid);
        end
        b_id = bid; b_resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout arready=%0b required=1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic r_recv(input int n);
        rready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int k = 0;
            while (!rvalid && k < 50) begin @(negedge clk); k++; end
            if (!rvalid) begin
                checks++; errors++;
                $display("FAIL r_timeout beat=%0d rvalid=%0b required=1", i, rvalid);
            end
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id[i] = rid;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int n, input int last_at);
        aw_send(id, addr, len, size, burst);
        w_send(n, last_at);
        b_recv();
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ar_send(id, addr, len, size, burst);
        r_recv(int'(len) + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000000", {awready, wready, arready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bresp, rresp, bid, rid} !== '0) begin
            errors++;
            $display("FAIL reset_resp_id got bresp=%0h rresp=%0h bid=%0h rid=%0h required=0", bresp, rresp, bid, rid);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h required=00000000", rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("FAIL reset_release got awready=%0b arready=%0b required=1,1", awready, arready);
        end
    endtask

    task automatic test_incr_wr_rd();
        logic [31:0] exp_d [4];
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin wr_data[i] = exp_d[i]; wr_strb[i] = 4'hF; end
        do_write(6'h2A, 32'h4000, 8'd3, 3'd2, INCR, 4, 3);
        checks++;
        if (b_resp !== OKAY || b_id !== 6'h2A) begin
            errors++; $display("FAIL incr_bresp got resp=%0h id=%0h required=0,2a", b_resp, b_id);
        end
        do_read(6'h15, 32'h4000, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp_d[i] || rd_resp[i] !== OKAY || rd_last[i] !== (i == 3) || rd_id[i] !== 6'h15) begin
                errors++;
                $display("FAIL incr_rbeat%0d got data=%h resp=%0h last=%0b id=%0h required=%h,0,%0b,15",
                         i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_strobe();
        wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
        do_write(6'h01, 32'h4010, 8'd0, 3'd2, INCR, 1, 0);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        do_write(6'h02, 32'h4010, 8'd0, 3'd2, INCR, 1, 0);
        checks++;
        if (b_resp !== OKAY) begin errors++; $display("FAIL strobe_bresp got=%0h required=0", b_resp); end
        do_read(6'h03, 32'h4010, 8'd0, 3'd2, INCR);
        checks++;
        if (rd_data[0] !== 32'h00BB00DD || rd_last[0] !== 1'b1) begin
            errors++; $display("FAIL strobe_rdata got=%h last=%0b required=00bb00dd,1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_read_boundary();
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r [4];
        exp_d = '{32'h77, 32'h88, 32'h0, 32'h0};
        exp_r = '{OKAY, OKAY, DECERR, DECERR};
        wr_data[0] = 32'h77; wr_data[1] = 32'h88; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        do_write(6'h04, 32'h4FF8, 8'd1, 3'd2, INCR, 2, 1);
        checks++;
        if (b_resp !== OKAY) begin errors++; $display("FAIL edge_bresp got=%0h required=0", b_resp); end
        do_read(6'h05, 32'h4FF8, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r[i] || rd_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL edge_rbeat%0d got data=%h resp=%0h last=%0b required=%h,%0h,%0b",
                         i, rd_data[i], rd_resp[i], rd_last[i], exp_d[i], exp_r[i], (i == 3));
            end
        end
    endtask

    task automatic test_write_errors();
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        do_write(6'h06, 32'h5000, 8'd0, 3'd2, INCR, 1, 0);
        checks++;
        if (b_resp !== DECERR || b_id !== 6'h06) begin
            errors++; $display("FAIL decerr_bresp got resp=%0h id=%0h required=3,06", b_resp, b_id);
        end
        do_read(6'h07, 32'h4000, 8'd0, 3'd2, INCR);
        checks++;
        if (rd_data[0] !== 32'h11) begin errors++; $display("FAIL decerr_nowrite got=%h required=00000011", rd_data[0]); end

        wr_data[0] = 32'h12345678; wr_data[1] = 32'h9ABCDEF0; wr_strb[1] = 4'hF;
        do_write(6'h08, 32'h4020, 8'd1, 3'd2, INCR, 2, 1);
        wr_data[0] = 32'hFFFFFFFF; wr_data[1] = 32'hFFFFFFFF;
        do_write(6'h09, 32'h4020, 8'd0, 3'd1, INCR, 1, 0);
        checks++;
        if (b_resp !== SLVERR) begin errors++; $display("FAIL size_bresp got=%0h required=2", b_resp); end
        do_write(6'h0A, 32'h4020, 8'd1, 3'd2, WRAP, 2, 1);
        checks++;
        if (b_resp !== SLVERR) begin errors++; $display("FAIL wrap_bresp got=%0h required=2", b_resp); end
        do_read(6'h0B, 32'h4020, 8'd1, 3'd2, INCR);
        checks++;
        if (rd_data[0] !== 32'h12345678 || rd_data[1] !== 32'h9ABCDEF0) begin
            errors++; $display("FAIL err_nowrite got=%h,%h required=12345678,9abcdef0", rd_data[0], rd_data[1]);
        end
        do_read(6'h0C, 32'h4020, 8'd1, 3'd2, WRAP);
        checks++;
        if (rd_resp[0] !== SLVERR || rd_resp[1] !== SLVERR || rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_read got resp=%0h,%0h data=%h,%h required=2,2,0,0", rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
        end
        do_write(6'h0D, 32'h4040, 8'd3, 3'd2, INCR, 2, 1);
        checks++;
        if (b_resp !== SLVERR) begin errors++; $display("FAIL early_wlast got=%0h required=2", b_resp); end
        aw_send(6'h0E, 32'h4040, 8'd1, 3'd2, INCR);
        w_send(2, -1);
        checks++;
        if (wready !== 1'b0) begin errors++; $display("FAIL no_wlast_wready got=%0b required=0", wready); end
        b_recv();
        checks++;
        if (b_resp !== SLVERR) begin errors++; $display("FAIL no_wlast_bresp got=%0h required=2", b_resp); end
    endtask

    task automatic test_backpressure();
        ar_send(6'h10, 32'h4000, 8'd3, 3'd2, INCR);
        r_recv(2);
        checks++;
        if (rd_data[0] !== 32'h11 || rd_data[1] !== 32'h22) begin
            errors++; $display("FAIL bp_first got=%h,%h required=11,22", rd_data[0], rd_data[1]);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h33 || rlast !== 1'b0 || rresp !== OKAY || rid !== 6'h10) begin
                errors++;
                $display("FAIL bp_rhold cyc=%0d got v=%0b d=%h l=%0b r=%0h id=%0h required=1,33,0,0,10",
                         c, rvalid, rdata, rlast, rresp, rid);
            end
            @(negedge clk);
        end
        r_recv(2);
        checks++;
        if (rd_data[0] !== 32'h33 || rd_data[1] !== 32'h44 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_rest got=%h,%h last=%0b%0b required=33,44,01", rd_data[0], rd_data[1], rd_last[0], rd_last[1]);
        end
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat rvalid=%0b required=0", rvalid); end

        wr_data[0] = 32'h5A5A0001; wr_strb[0] = 4'hF;
        aw_send(6'h11, 32'h4030, 8'd0, 3'd2, INCR);
        w_send(1, 0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== OKAY || bid !== 6'h11) begin
                errors++;
                $display("FAIL bp_bhold cyc=%0d got v=%0b r=%0h id=%0h required=1,0,11", c, bvalid, bresp, bid);
            end
            @(negedge clk);
        end
        b_recv();
        checks++;
        if (bvalid !== 1'b0 || b_id !== 6'h11) begin
            errors++; $display("FAIL bp_bdone got v=%0b id=%0h required=0,11", bvalid, b_id);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin wr_data[i] = 32'h55; wr_strb[i] = 4'hF; end
        do_write(6'h12, 32'h4100, 8'd2, 3'd2, INCR, 3, 2);
        wr_data[0] = 32'hA0; wr_data[1] = 32'hA1;
        aw_send(6'h13, 32'h4100, 8'd7, 3'd2, INCR);
        w_send(2, -1);
        wdata = 32'hA2; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
        bready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b0 || awready !== 1'b0) begin
                errors++; $display("FAIL rst_mid_hold got bvalid=%0b awready=%0b required=0,0", bvalid, awready);
            end
        end
        rst = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL rst_mid_awready got=%0b required=1", awready); end
        repeat (4) begin
            checks++;
            if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_bvalid got=%0b required=0", bvalid); end
            @(negedge clk);
        end
        bready = 1'b0;
        do_read(6'h14, 32'h4100, 8'd2, 3'd2, INCR);
        checks++;
        if (rd_data[0] !== 32'hA0 || rd_data[1] !== 32'hA1 || rd_data[2] !== 32'h55) begin
            errors++;
            $display("FAIL rst_mid_mem got=%h,%h,%h required=a0,a1,55", rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    initial begin
        test_reset();
        test_incr_wr_rd();
        test_strobe();
        test_read_boundary();
        test_write_errors();
        test_backpressure();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
